// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the pipeline MEM stage and a loader/debug port.
// Define DMEM_ARB_RR_EN for round-robin contention; default is cpu priority with ext anti-starvation.
module dmem_arbiter #(
    parameter int ADDRESS_LINE = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDRESS_LINE-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    output logic                    cpu_gnt,
    output logic                    cpu_stall,
    output logic                    cpu_rvalid,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    input  logic                    ext_req,
    input  logic                    ext_we,
    input  logic                    ext_lock,
    input  logic [ADDRESS_LINE-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0]   ext_wdata,
    output logic                    ext_gnt,
    output logic                    ext_rvalid,
    output logic [DATA_WIDTH-1:0]   ext_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDRESS_LINE-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_IDLE,
        OWN_CPU,
        OWN_EXT,
        OWN_EXT_LOCKED
    } owner_t;

    owner_t           r_owner;
    owner_t           w_owner_next;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_cpu_pend;
    logic             r_ext_pend;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_WIDTH-1:0] r_ext_rdata;
    logic             w_cpu_gnt;
    logic             w_ext_gnt;
`ifdef DMEM_ARB_RR_EN
    logic             r_last_ext;   // last_winner: 0 = CPU, 1 = EXT
`endif

    // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        w_cpu_gnt    = 1'b0;
        w_ext_gnt    = 1'b0;
        w_owner_next = OWN_IDLE;
        if (!reset) begin
            if (ext_req && r_owner == OWN_EXT_LOCKED) begin
                w_ext_gnt = 1'b1;
            end else if (cpu_req && ext_req) begin
`ifdef DMEM_ARB_RR_EN
                w_ext_gnt = ~r_last_ext;
                w_cpu_gnt = r_last_ext;
`else
                w_ext_gnt = (r_starve_cnt == CNT_MAX);
                w_cpu_gnt = (r_starve_cnt != CNT_MAX);
`endif
            end else begin
                w_cpu_gnt = cpu_req;
                w_ext_gnt = ext_req;
            end
        end
        if (w_ext_gnt) begin
            w_owner_next = ext_lock ? OWN_EXT_LOCKED : OWN_EXT;
        end else if (w_cpu_gnt) begin
            w_owner_next = OWN_CPU;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner      <= OWN_IDLE;
            r_starve_cnt <= '0;
            r_cpu_pend   <= 1'b0;
            r_ext_pend   <= 1'b0;
            r_cpu_rdata  <= '0;
            r_ext_rdata  <= '0;
`ifdef DMEM_ARB_RR_EN
            r_last_ext   <= 1'b0;
`endif
        end else begin
            r_owner    <= w_owner_next;
            r_cpu_pend <= w_cpu_gnt & ~cpu_we;
            r_ext_pend <= w_ext_gnt & ~ext_we;
            if (r_cpu_pend) r_cpu_rdata <= mem_rdata;
            if (r_ext_pend) r_ext_rdata <= mem_rdata;
            if (ext_req && !w_ext_gnt) begin
                if (r_starve_cnt != CNT_MAX) r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end else begin
                r_starve_cnt <= '0;
            end
`ifdef DMEM_ARB_RR_EN
            if (w_cpu_gnt || w_ext_gnt) r_last_ext <= w_ext_gnt;
`endif
        end
    end

    assign cpu_gnt   = w_cpu_gnt;
    assign ext_gnt   = w_ext_gnt;
    assign cpu_stall = cpu_req & ~w_cpu_gnt;

    assign mem_en    = w_cpu_gnt | w_ext_gnt;
    assign mem_we    = (w_cpu_gnt & cpu_we) | (w_ext_gnt & ext_we);
    assign mem_addr  = ({ADDRESS_LINE{w_cpu_gnt}} & cpu_addr) | ({ADDRESS_LINE{w_ext_gnt}} & ext_addr);
    assign mem_wdata = ({DATA_WIDTH{w_cpu_gnt}} & cpu_wdata) | ({DATA_WIDTH{w_ext_gnt}} & ext_wdata);

    // Read responses are masked while reset is high, so a read granted just before reset is dropped.
    assign cpu_rvalid = r_cpu_pend & ~reset;
    assign ext_rvalid = r_ext_pend & ~reset;
    assign cpu_rdata  = reset ? '0 : (r_cpu_pend ? mem_rdata : r_cpu_rdata);
    assign ext_rdata  = reset ? '0 : (r_ext_pend ? mem_rdata : r_ext_rdata);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a behavioural arbitration/memory model.
module tb_dmem_arbiter;

    localparam int LIMIT = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, ext_req, ext_we, ext_lock;
    logic [7:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
    logic       cpu_gnt, cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid;
    logic [7:0] cpu_rdata, ext_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = 8'h00;

    int checks = 0;
    int errors = 0;

    // Memory stub driven by the DUT's memory port
    logic [7:0] stub_mem [256];
    // Model state
    logic [7:0] m_mem [256];
    int         m_starve;
    bit         m_locked, m_last_ext;
    bit         m_cpu_pend, m_ext_pend;
    logic [7:0] m_cpu_pdata, m_ext_pdata, m_cpu_hold, m_ext_hold;

    dmem_arbiter #(.ADDRESS_LINE(8), .DATA_WIDTH(8), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_en && mem_we) stub_mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= stub_mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        stub_mem[a] = d;
        m_mem[a]    = d;
    endtask

    // Drive one cycle of inputs, compare all outputs with the model, then advance the model.
    task automatic apply(input logic rst,
                         input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                         input logic er, input logic ew, input logic el,
                         input logic [7:0] ea, input logic [7:0] ed);
        bit cg, eg, both;
        logic [7:0] e_cpu_rd, e_ext_rd;
        @(negedge clock);
        reset = rst; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        ext_req = er; ext_we = ew; ext_lock = el; ext_addr = ea; ext_wdata = ed;
        #1;
        cg = 0; eg = 0;
        both = cr && er;
        if (!rst) begin
            if (er && m_locked) eg = 1;
            else if (both) begin
`ifdef DMEM_ARB_RR_EN
                eg = !m_last_ext;
`else
                eg = (m_starve == LIMIT);
`endif
                cg = !eg;
            end else begin
                cg = cr;
                eg = er;
            end
        end
        e_cpu_rd = rst ? 8'h00 : (m_cpu_pend ? m_cpu_pdata : m_cpu_hold);
        e_ext_rd = rst ? 8'h00 : (m_ext_pend ? m_ext_pdata : m_ext_hold);

        check("cpu_gnt", cpu_gnt, cg);
        check("ext_gnt", ext_gnt, eg);
        check("cpu_stall", cpu_stall, cr && !cg);
        check("mem_en", mem_en, cg || eg);
        check("mem_we", mem_we, cg ? cw : (eg ? ew : 1'b0));
        check("mem_addr", mem_addr, cg ? ca : (eg ? ea : 8'h00));
        check("mem_wdata", mem_wdata, cg ? cd : (eg ? ed : 8'h00));
        check("cpu_rvalid", cpu_rvalid, !rst && m_cpu_pend);
        check("ext_rvalid", ext_rvalid, !rst && m_ext_pend);
        check("cpu_rdata", cpu_rdata, e_cpu_rd);
        check("ext_rdata", ext_rdata, e_ext_rd);

        if (rst) begin
            m_starve = 0; m_locked = 0; m_last_ext = 0;
            m_cpu_pend = 0; m_ext_pend = 0; m_cpu_hold = 0; m_ext_hold = 0;
        end else begin
            if (m_cpu_pend) m_cpu_hold = m_cpu_pdata;
            if (m_ext_pend) m_ext_hold = m_ext_pdata;
            m_cpu_pend = cg && !cw;
            m_ext_pend = eg && !ew;
            if (m_cpu_pend) m_cpu_pdata = m_mem[ca];
            if (m_ext_pend) m_ext_pdata = m_mem[ea];
            if (cg && cw) m_mem[ca] = cd;
            if (eg && ew) m_mem[ea] = ed;
            m_locked = eg && el;
            m_starve = (er && !eg) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
            if (cg || eg) m_last_ext = eg;
        end
    endtask

    task automatic idle(input logic rst);
        apply(rst, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            stub_mem[i] = 8'h00;
            m_mem[i]    = 8'h00;
        end
        m_cpu_pdata = 0; m_ext_pdata = 0;
        idle(1); idle(1);

        // Lone cpu read: granted same cycle, data next cycle
        preload(8'h10, 8'hA5);
        apply(0, 1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        check("lone_cpu_gnt", cpu_gnt, 1'b1);
        check("lone_cpu_stall", cpu_stall, 1'b0);
        idle(0);
        check("lone_cpu_rvalid", cpu_rvalid, 1'b1);
        check("lone_cpu_rdata", cpu_rdata, 8'hA5);

        // Reset right after a granted read drops the response and blocks grants
        apply(0, 1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        apply(1, 1, 0, 8'h10, 8'h00, 1, 0, 0, 8'h20, 8'h00);
        check("rst_cpu_rvalid", cpu_rvalid, 1'b0);
        check("rst_cpu_rdata", cpu_rdata, 8'h00);
        check("rst_no_gnt", {cpu_gnt, ext_gnt, mem_en}, 3'b000);
        apply(0, 1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        check("post_rst_gnt", cpu_gnt, 1'b1);

        // Continuous contention from a fresh reset
        idle(1);
        for (int i = 0; i < 10; i++) begin
            apply(0, 1, 1, 8'h30, 8'(i), 1, 1, 0, 8'h40, 8'(i + 100));
`ifdef DMEM_ARB_RR_EN
            check("rr_ext_gnt", ext_gnt, (i % 2) == 0);
`else
            check("starve_ext_gnt", ext_gnt, (i % 5) == 4);
            check("starve_cpu_stall", cpu_stall, (i % 5) == 4);
`endif
        end

        // Locked ext write burst of 3 holds off the cpu
        idle(1);
        apply(0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h50, 8'h11);
        check("lock_gnt0", ext_gnt, 1'b1);
        for (int i = 1; i < 3; i++) begin
            apply(0, 1, 0, 8'h50, 8'h00, 1, 1, 1, 8'(8'h50 + i), 8'(8'h11 + i));
            check("lock_gnt", ext_gnt, 1'b1);
            check("lock_stall", cpu_stall, 1'b1);
        end
        apply(0, 1, 0, 8'h51, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        check("lock_release", cpu_gnt, 1'b1);
        idle(0);
        check("burst_data", cpu_rdata, 8'h12);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
                  ($urandom_range(0, 2) != 0), 1'($urandom), ($urandom_range(0, 3) == 0),
                  8'($urandom_range(0, 15)), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDRESS_LINE, default 8, SHALL set the data-memory address width.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the data-memory word width.
REQ-003 Parameter STARVE_LIMIT, default 4, SHALL set the maximum number of consecutive cycles an external request may be denied.
REQ-004 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be synchronous and active-high.
REQ-006 cpu_req, cpu_we  input  1 each  SHALL be the pipeline MEM-stage access request and write enable.
REQ-007 cpu_addr  input  ADDRESS_LINE; cpu_wdata  input  DATA_WIDTH  SHALL be the pipeline address and write data.
REQ-008 cpu_gnt  output  1; cpu_stall  output  1  SHALL be the pipeline grant and pipeline stall (cpu_stall = cpu_req & ~cpu_gnt).
REQ-009 cpu_rvalid  output  1; cpu_rdata  output  DATA_WIDTH  SHALL be the pipeline read response.
REQ-010 ext_req, ext_we, ext_lock  input  1 each  SHALL be the loader/debug request, write enable and burst lock.
REQ-011 ext_addr  input  ADDRESS_LINE; ext_wdata  input  DATA_WIDTH  SHALL be the loader address and write data.
REQ-012 ext_gnt, ext_rvalid  output  1; ext_rdata  output  DATA_WIDTH  SHALL be the loader grant and read response.
REQ-013 mem_en, mem_we  output  1; mem_addr  output  ADDRESS_LINE; mem_wdata  output  DATA_WIDTH  SHALL drive the data memory.
REQ-014 mem_rdata  input  DATA_WIDTH  SHALL be the memory read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-015 At most one of cpu_gnt/ext_gnt SHALL be high in any cycle; grants are combinational from the current requests and registered state.
REQ-016 A lone requester SHALL be granted in the same cycle.
REQ-017 mem_en SHALL equal cpu_gnt|ext_gnt; mem_we/addr/wdata SHALL be muxed from the granted requester, and SHALL be 0 when there is no grant.
REQ-018 A granted read SHALL produce the requester's rvalid high for exactly one cycle, in the cycle after the grant, with rdata = mem_rdata; a granted write SHALL produce no rvalid.
REQ-019 rdata outputs SHALL hold their last value while rvalid is low.
REQ-020 Arbitration SHALL be tracked by register owner in {IDLE, CPU, EXT, EXT_LOCKED}, updated each cycle to the granted requester (IDLE if none).
REQ-021 While owner=EXT_LOCKED and ext_req=1, ext SHALL be granted regardless of cpu_req; the state is entered when ext is granted with ext_lock=1 and exited when ext_lock=0 or ext_req=0.
REQ-022 Register starve_cnt SHALL increment (saturating at STARVE_LIMIT) each cycle ext_req=1 and ext_gnt=0, and SHALL clear on ext_gnt or ext_req=0.
REQ-023 Contention (both requests, not locked) SHALL be resolved per REQ-030/031.
REQ-024 Requests SHALL be held stable by the requester until granted; changes before the grant SHALL be treated as new requests without error.

Reset
REQ-025 While reset=1: owner=IDLE, starve_cnt=0, last_winner=CPU, both rvalid=0, both rdata=0.
REQ-026 During reset all grants and mem_en SHALL be 0; a read granted in the cycle reset asserts SHALL NOT produce rvalid.
REQ-027 The first grant SHALL be possible in the first cycle after reset deasserts.

Configuration
REQ-028 Macro DMEM_ARB_RR_EN SHALL select the contention policy.
REQ-029 The interface SHALL be identical with and without the macro.
REQ-030 With DMEM_ARB_RR_EN defined: on contention the requester not equal to last_winner SHALL be granted, and last_winner SHALL update on every grant; starve_cnt SHALL still count but SHALL not affect grants.
REQ-031 Without DMEM_ARB_RR_EN: on contention cpu SHALL win unless starve_cnt==STARVE_LIMIT, in which case ext SHALL win.

Verification
REQ-032 cpu read addr 0x10 alone, mem_rdata=0xA5 -> cpu_gnt same cycle, cpu_rvalid=1 and cpu_rdata=0xA5 next cycle, cpu_stall=0.
REQ-033 Both request continuously, no macro, STARVE_LIMIT=4 -> cpu granted 4 cycles, ext granted 5th cycle, cpu_stall=1 that cycle.
REQ-034 Both request continuously, DMEM_ARB_RR_EN -> grants alternate ext, cpu, ext, ... after reset (last_winner=CPU).
REQ-035 ext_lock=1 burst of 3 writes with cpu_req=1 -> ext_gnt 3 consecutive cycles, cpu_stall=1 throughout, cpu granted the cycle ext_req drops.
REQ-036 Reset asserted the cycle after a granted cpu read -> cpu_rvalid=0, cpu_rdata=0, owner=IDLE, no grant until reset deasserts.
